am_demod_pipelined: RTL and testbench

Pipelined AM envelope demodulator. Computes floor(sqrt(I² + Q²)) at one sample per clock with a valid qualifier, then optionally removes the carrier DC level to produce a signed audio sample. It sits after the I/Q decimation chain. It generalises the single-register AM demodulator with a fully pipelined square root, valid tracking through the pipe, and a DC-blocking output stage.

---
 rtl/am_demod_pipelined.sv | 165 ++++++++++++++++
 tb/tb_am_demod_pipelined.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/am_demod_pipelined.sv
// Pipelined AM envelope demodulator: floor(sqrt(I^2 + Q^2)) at one sample per clock,
// followed by a DC-tracking stage that turns the envelope into a signed audio sample.
module am_demod_pipelined #(
   parameter int DATA_WIDTH = 12,
   parameter int DC_SHIFT   = 10
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] inphase,
   input  logic signed [DATA_WIDTH-1:0] quadrature,
   input  logic                         dc_en,
   input  logic                         dc_clr,
   output logic                         mag_valid,
   output logic        [DATA_WIDTH-1:0] amdemod_out,
   output logic                         audio_valid,
   output logic signed [DATA_WIDTH-1:0] audio_out
);

   localparam int DW  = DATA_WIDTH;
   localparam int N   = 2 * DW + 2;
   localparam int NST = DW + 1;
   localparam int RTW = DW + 1;
   localparam int RW  = DW + 4;
   localparam int AW  = DW + DC_SHIFT;

   logic signed [2*DW-1:0] prodI, prodQ;
   logic        [2*DW-1:0] sqI_q, sqQ_q;
   logic                   vM_q;
   logic        [N-1:0]    sum_q;
   logic                   vS_q;

   assign prodI = (2*DW)'(inphase) * (2*DW)'(inphase);
   assign prodQ = (2*DW)'(quadrature) * (2*DW)'(quadrature);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sqI_q <= '0;
         sqQ_q <= '0;
         vM_q  <= 1'b0;
         sum_q <= '0;
         vS_q  <= 1'b0;
      end else begin
         sqI_q <= prodI;
         sqQ_q <= prodQ;
         vM_q  <= in_valid;
         sum_q <= N'(sqI_q) + N'(sqQ_q);
         vS_q  <= vM_q;
      end
   end

   logic signed [RW-1:0]  rem_q   [NST-1];
   logic        [RTW-1:0] root_q  [NST-1];
   logic        [N-1:0]   rad_q   [NST-1];
   logic                  v_q     [NST-1];
   logic signed [RW-1:0]  remIn   [NST];
   logic signed [RW-1:0]  shift_d [NST];
   logic signed [RW-1:0]  rem_d   [NST];
   logic        [RTW-1:0] rootIn  [NST];
   logic        [RTW-1:0] root_d  [NST];
   logic        [N-1:0]   radIn   [NST];
   logic        [N-1:0]   rad_d   [NST];
   logic                  vIn     [NST];
   logic        [DW-1:0]  magOut_q;
   logic                  magValid_q;

   // Non-restoring square root: a negative partial remainder is corrected by adding
   // (root<<2)|3 in the next stage instead of being restored, so the root bit is just
   // the inverted sign of the new remainder.
   always_comb begin
      remIn[0]  = '0;
      rootIn[0] = '0;
      radIn[0]  = sum_q;
      vIn[0]    = vS_q;
      for (int k = 1; k < NST; k++) begin
         remIn[k]  = rem_q[k-1];
         rootIn[k] = root_q[k-1];
         radIn[k]  = rad_q[k-1];
         vIn[k]    = v_q[k-1];
      end
      for (int k = 0; k < NST; k++) begin
         shift_d[k] = (remIn[k] <<< 2) | RW'(radIn[k][N-1:N-2]);
         if (remIn[k][RW-1]) begin
            rem_d[k] = shift_d[k] + RW'({rootIn[k], 2'b11});
         end else begin
            rem_d[k] = shift_d[k] - RW'({rootIn[k], 2'b01});
         end
         root_d[k] = {rootIn[k][RTW-2:0], ~rem_d[k][RW-1]};
         rad_d[k]  = {radIn[k][N-3:0], 2'b00};
      end
   end

   // The last stage only loads on a valid slot so amdemod_out holds through bubbles.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < NST - 1; k++) begin
            rem_q[k]  <= '0;
            root_q[k] <= '0;
            rad_q[k]  <= '0;
            v_q[k]    <= 1'b0;
         end
         magOut_q   <= '0;
         magValid_q <= 1'b0;
      end else begin
         for (int k = 0; k < NST - 1; k++) begin
            rem_q[k]  <= rem_d[k];
            root_q[k] <= root_d[k];
            rad_q[k]  <= rad_d[k];
            v_q[k]    <= vIn[k];
         end
         magValid_q <= vIn[NST-1];
         if (vIn[NST-1]) begin
            magOut_q <= root_d[NST-1][DW-1:0];
         end
      end
   end

   logic        [AW-1:0] acc_q, acc_d;
   logic        [DW-1:0] mean;
   logic signed [DW:0]   diff;
   logic signed [DW-1:0] audio_q, audio_d;
   logic                 audioValid_q;

   // DC removal: acc tracks mean * 2^DC_SHIFT; a clear in the same cycle as a sample
   // makes that sample see a zero mean and wins over the accumulator update.
   always_comb begin
      acc_d   = acc_q;
      audio_d = audio_q;
      mean    = dc_clr ? '0 : acc_q[AW-1:DC_SHIFT];
      diff    = $signed({1'b0, magOut_q}) - $signed({1'b0, mean});
      if (magValid_q) begin
         if (dc_en) begin
            if (diff[DW] != diff[DW-1]) begin
               audio_d = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end else begin
               audio_d = diff[DW-1:0];
            end
            acc_d = acc_q + AW'(diff);
         end else begin
            audio_d = magOut_q[DW-1] ? {1'b0, {(DW-1){1'b1}}} : {1'b0, magOut_q[DW-2:0]};
         end
      end
      if (dc_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         acc_q        <= '0;
         audio_q      <= '0;
         audioValid_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         audio_q      <= audio_d;
         audioValid_q <= magValid_q;
      end
   end

   assign mag_valid   = magValid_q;
   assign amdemod_out = magOut_q;
   assign audio_valid = audioValid_q;
   assign audio_out   = audio_q;

endmodule

// File: tb/tb_am_demod_pipelined.sv
// Self-checking bench for am_demod_pipelined: table vectors, hand sequences and random
// traffic, all checked every cycle against a delay-line + floor-sqrt + DC-tracker model.
module tb_am_demod_pipelined;

   localparam int DW  = 12;
   localparam int SH  = 4;
   localparam int LAT = DW + 3;

   logic                 clk = 1'b0;
   logic                 arst;
   logic                 inValid;
   logic signed [DW-1:0] iIn, qIn;
   logic                 dcEn, dcClr;
   logic                 magValid, audioValid;
   logic        [DW-1:0] magOut;
   logic signed [DW-1:0] audioOut;

   always #5 clk = ~clk;

   am_demod_pipelined #(.DATA_WIDTH(DW), .DC_SHIFT(SH)) dut (
      .clk        (clk),
      .arst       (arst),
      .in_valid   (inValid),
      .inphase    (iIn),
      .quadrature (qIn),
      .dc_en      (dcEn),
      .dc_clr     (dcClr),
      .mag_valid  (magValid),
      .amdemod_out(magOut),
      .audio_valid(audioValid),
      .audio_out  (audioOut)
   );

   typedef struct {
      int i;
      int q;
      int expMag;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   int   expOverride;
   int   magPipe[$];
   int   accModel, lastMag, lastAudio, pendAudio;
   bit   pendV;
   bit   logAudio;
   int   audioLog[$];

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int isqrt(input longint s);
      int r = 0;
      while (longint'(r + 1) * longint'(r + 1) <= s) r++;
      return r;
   endfunction

   function automatic int clampS(input int v);
      if (v > 2**(DW-1) - 1) return 2**(DW-1) - 1;
      if (v < -(2**(DW-1))) return -(2**(DW-1));
      return v;
   endfunction

   // Reference model: samples sit in a LAT-deep delay line, then the DC tracker
   // consumes them with whatever dc_en/dc_clr are presented at that moment.
   always @(negedge clk) begin : monitor
      int e, mean, diff;
      if (arst) begin
         checkOutput("rstMagValid", int'(magValid), 0);
         checkOutput("rstMagOut", int'(magOut), 0);
         checkOutput("rstAudioValid", int'(audioValid), 0);
         checkOutput("rstAudioOut", int'(audioOut), 0);
         magPipe.delete();
         accModel  = 0;
         lastMag   = 0;
         lastAudio = 0;
         pendV     = 1'b0;
      end else begin
         checkOutput("audioValid", int'(audioValid), int'(pendV));
         if (pendV) begin
            checkOutput("audioOut", int'(audioOut), pendAudio);
            lastAudio = pendAudio;
            if (logAudio) audioLog.push_back(int'(audioOut));
         end else begin
            checkOutput("audioHold", int'(audioOut), lastAudio);
         end
         if (inValid) begin
            magPipe.push_back(expOverride >= 0 ? expOverride
                              : isqrt(longint'(iIn) * longint'(iIn) + longint'(qIn) * longint'(qIn)));
         end else begin
            magPipe.push_back(-1);
         end
         e = -1;
         if (magPipe.size() > LAT) e = magPipe.pop_front();
         checkOutput("magValid", int'(magValid), int'(e >= 0));
         if (e >= 0) begin
            checkOutput("magOut", int'(magOut), e);
            lastMag = e;
            mean = dcClr ? 0 : (accModel >>> SH);
            diff = e - mean;
            if (dcEn) begin
               pendAudio = clampS(diff);
               accModel += diff;
            end else begin
               pendAudio = (e > 2**(DW-1) - 1) ? 2**(DW-1) - 1 : e;
            end
            pendV = 1'b1;
         end else begin
            checkOutput("magHold", int'(magOut), lastMag);
            pendV = 1'b0;
         end
         if (dcClr) accModel = 0;
      end
   end

   task automatic applyStimulus(input bit v, input int i, input int q, input int ov);
      @(posedge clk);
      #1;
      inValid     = v;
      iIn         = DW'(i);
      qIn         = DW'(q);
      expOverride = ov;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, $urandom_range(0, 4095) - 2048,
                                                $urandom_range(0, 4095) - 2048, -1);
   endtask

   task automatic pulseClear();
      applyStimulus(1'b0, 0, 0, -1);
      dcClr = 1'b1;
      applyStimulus(1'b0, 0, 0, -1);
      dcClr = 1'b0;
   endtask

   vec_t vecs[6];
   bit [6:0] bubbles;
   int nonMono, nonZero;

   initial begin
      vecs[0] = '{i: 3,     q: 4,     expMag: 5};
      vecs[1] = '{i: -2048, q: -2048, expMag: 2896};
      vecs[2] = '{i: 2047,  q: 0,     expMag: 2047};
      vecs[3] = '{i: 0,     q: 0,     expMag: 0};
      vecs[4] = '{i: -2048, q: 2047,  expMag: 2895};
      vecs[5] = '{i: 1,     q: 1,     expMag: 1};

      arst = 1'b1; inValid = 1'b0; iIn = '0; qIn = '0;
      dcEn = 1'b1; dcClr = 1'b0; expOverride = -1; logAudio = 1'b0;
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;

      // single sample, then back-to-back extremes
      applyStimulus(1'b1, vecs[0].i, vecs[0].q, vecs[0].expMag);
      idle(20);
      for (int k = 1; k < 6; k++) applyStimulus(1'b1, vecs[k].i, vecs[k].q, vecs[k].expMag);
      idle(20);

      bubbles = 7'b1010011;
      for (int b = 6; b >= 0; b--) applyStimulus(bubbles[b], $urandom_range(0, 4095) - 2048,
                                                 $urandom_range(0, 4095) - 2048, -1);
      idle(20);

      // reset while the pipe is full: nothing accepted earlier may emerge afterwards
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, $urandom_range(0, 4095) - 2048,
                                                 $urandom_range(0, 4095) - 2048, -1);
      @(posedge clk);
      #1 arst = 1'b1;
      #1;
      checkOutput("rstImmMagValid", int'(magValid), 0);
      checkOutput("rstImmAudioValid", int'(audioValid), 0);
      checkOutput("rstImmAudioOut", int'(audioOut), 0);
      idle(3);
      arst = 1'b0;
      idle(25);

      for (int k = 0; k < 300; k++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 4095) - 2048,
                       $urandom_range(0, 4095) - 2048, -1);
         if ($urandom_range(0, 19) == 0) dcEn = ~dcEn;
         dcClr = ($urandom_range(0, 49) == 0);
      end
      dcEn = 1'b1; dcClr = 1'b0;
      idle(20);

      // DC tracking from a cleared accumulator
      pulseClear();
      audioLog.delete();
      logAudio = 1'b1;
      for (int k = 0; k < 300; k++) applyStimulus(1'b1, 1000, 0, -1);
      idle(20);
      logAudio = 1'b0;
      checkOutput("dcCount", audioLog.size(), 300);
      checkOutput("dcFirst", audioLog[0], 1000);
      nonMono = 0; nonZero = 0;
      for (int k = 1; k < audioLog.size(); k++) if (audioLog[k] > audioLog[k-1]) nonMono++;
      for (int k = 199; k < audioLog.size(); k++) if (audioLog[k] != 0) nonZero++;
      checkOutput("dcMonotone", nonMono, 0);
      checkOutput("dcSettled", nonZero, 0);

      pulseClear();
      audioLog.delete();
      logAudio = 1'b1;
      applyStimulus(1'b1, 1000, 0, -1);
      idle(20);
      checkOutput("dcAfterClr", audioLog[0], 1000);

      // bypass with saturation, then tracking resumes from the held accumulator
      dcEn = 1'b0;
      audioLog.delete();
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, -2048, -2048, -1);
      idle(20);
      checkOutput("bypassCount", audioLog.size(), 4);
      checkOutput("bypassSat", audioLog[3], 2047);
      dcEn = 1'b1;
      audioLog.delete();
      applyStimulus(1'b1, 1000, 0, -1);
      idle(20);
      checkOutput("resumeFromAcc", audioLog[0], 1000 - 1000 / 16);
      logAudio = 1'b0;

      idle(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
